emem_if_mc: RTL and testbench



---
 rtl/emem_if_mc.sv | 197 +++++++++++++++++++
 tb/tb_emem_if_mc.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/emem_if_mc.sv
// rtl/emem_if_mc.sv - multi-channel strided external-memory load/store engine
// Round-robin grants one command at a time; load data returns through a credit-bounded FIFO.

module emem_if_mc #(
    parameter int NUM_CH     = 4,
    parameter int WIDTH_DATA = 32,
    parameter int WIDTH_ADDR = 32,
    parameter int WIDTH_LEN  = 16,
    parameter int DEPTH_RSP  = 8
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic [NUM_CH-1:0]            I_Cmd_Valid,
    input  logic [NUM_CH-1:0]            I_Cmd_St,
    input  logic [NUM_CH*WIDTH_ADDR-1:0] I_Cmd_Addr,
    input  logic [NUM_CH*WIDTH_ADDR-1:0] I_Cmd_Stride,
    input  logic [NUM_CH*WIDTH_LEN-1:0]  I_Cmd_Len,
    output logic [NUM_CH-1:0]            O_Cmd_Ready,
    input  logic [NUM_CH-1:0]            I_St_Valid,
    input  logic [NUM_CH*WIDTH_DATA-1:0] I_St_Data,
    output logic [NUM_CH-1:0]            O_St_Ready,
    output logic                         O_Ld_Valid,
    output logic [WIDTH_DATA-1:0]        O_Ld_Data,
    output logic [$clog2(NUM_CH)-1:0]    O_Ld_Ch,
    input  logic                         I_Ld_Ready,
    output logic [NUM_CH-1:0]            O_Done,
    output logic                         O_Mem_Req,
    output logic                         O_Mem_We,
    output logic [WIDTH_ADDR-1:0]        O_Mem_Addr,
    output logic [WIDTH_DATA-1:0]        O_Mem_WData,
    input  logic                         I_Mem_Ack,
    input  logic                         I_Mem_RValid,
    input  logic [WIDTH_DATA-1:0]        I_Mem_RData
);

    localparam int CW = $clog2(NUM_CH);
    localparam int PW = $clog2(DEPTH_RSP);
    localparam int QW = PW + 1;

    localparam logic [WIDTH_LEN-1:0] LEN_ONE    = 1;
    localparam logic [PW-1:0]        PTR_ONE    = 1;
    localparam logic [QW-1:0]        CNT_ONE    = 1;
    localparam logic [QW-1:0]        CNT_FULL   = DEPTH_RSP;
    localparam logic [QW:0]          CREDIT_MAX = DEPTH_RSP;

    typedef enum logic [1:0] {IDLE, LOAD, STORE, DRAIN} state_t;

    state_t                  state, state_next;
    logic [CW-1:0]           ptr, ch, grant_ch, cand;
    logic                    grant_found;
    logic [WIDTH_LEN-1:0]    grant_len;
    logic [WIDTH_ADDR-1:0]   cur_addr, stride;
    logic [WIDTH_LEN-1:0]    remaining, pops_left;
    logic [QW-1:0]           outstanding, fifo_count;
    logic [QW:0]             credit_used;
    logic [PW-1:0]           wr_ptr, rd_ptr;
    logic [NUM_CH-1:0]       done_q, done_set;
    logic                    mem_req, ack_fire, load_ack;
    logic                    fifo_empty, fifo_full, push, pop, rsp_valid;
    logic [CW+WIDTH_DATA-1:0] fifo_mem [DEPTH_RSP];
    logic [CW+WIDTH_DATA-1:0] rd_word;

    assign grant_len   = I_Cmd_Len[int'(grant_ch)*WIDTH_LEN +: WIDTH_LEN];
    assign credit_used = {1'b0, outstanding} + {1'b0, fifo_count};

    always_comb begin
        state_next  = state;
        mem_req     = 1'b0;
        done_set    = '0;
        O_Cmd_Ready = '0;
        O_St_Ready  = '0;
        grant_found = 1'b0;
        grant_ch    = '0;
        cand        = '0;
        for (int i = 1; i <= NUM_CH; i++) begin
            cand = CW'((int'(ptr) + i) % NUM_CH);
            if (!grant_found && I_Cmd_Valid[cand]) begin
                grant_found = 1'b1;
                grant_ch    = cand;
            end
        end
        case (state)
            IDLE: begin
                // reset gating keeps the accept pulse low while held in reset
                if (grant_found && reset) begin
                    O_Cmd_Ready[grant_ch] = 1'b1;
                    if (grant_len == '0)
                        done_set[grant_ch] = 1'b1;
                    else
                        state_next = I_Cmd_St[grant_ch] ? STORE : LOAD;
                end
            end
            LOAD: begin
                mem_req = (remaining != '0) && (credit_used < CREDIT_MAX);
                if (mem_req && I_Mem_Ack && remaining == LEN_ONE)
                    state_next = DRAIN;
            end
            STORE: begin
                mem_req = I_St_Valid[ch];
                if (mem_req && I_Mem_Ack) begin
                    O_St_Ready[ch] = 1'b1;
                    if (remaining == LEN_ONE) begin
                        done_set[ch] = 1'b1;
                        state_next   = IDLE;
                    end
                end
            end
            DRAIN: begin
                if (outstanding == '0 && pops_left == '0) begin
                    done_set[ch] = 1'b1;
                    state_next   = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign ack_fire  = mem_req && I_Mem_Ack;
    assign load_ack  = ack_fire && (state == LOAD);
    // a return with nothing outstanding belongs to an aborted transfer
    assign rsp_valid = I_Mem_RValid && (outstanding != '0);
    assign fifo_empty = (fifo_count == '0);
    assign fifo_full  = (fifo_count == CNT_FULL);
    assign pop        = !fifo_empty && I_Ld_Ready;
    assign push       = rsp_valid && (!fifo_full || pop);
    assign rd_word    = fifo_mem[rd_ptr];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ptr         <= '0;
            ch          <= '0;
            cur_addr    <= '0;
            stride      <= '0;
            remaining   <= '0;
            pops_left   <= '0;
            outstanding <= '0;
            fifo_count  <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            done_q      <= '0;
        end else begin
            done_q <= done_set;
            if (state == IDLE && grant_found) begin
                ptr       <= grant_ch;
                ch        <= grant_ch;
                cur_addr  <= I_Cmd_Addr[int'(grant_ch)*WIDTH_ADDR +: WIDTH_ADDR];
                stride    <= I_Cmd_Stride[int'(grant_ch)*WIDTH_ADDR +: WIDTH_ADDR];
                remaining <= grant_len;
                pops_left <= I_Cmd_St[grant_ch] ? '0 : grant_len;
            end else if (ack_fire) begin
                cur_addr  <= cur_addr + stride;
                remaining <= remaining - LEN_ONE;
            end
            if (pop && pops_left != '0)
                pops_left <= pops_left - LEN_ONE;
            case ({load_ack, rsp_valid})
                2'b10:   outstanding <= outstanding + CNT_ONE;
                2'b01:   outstanding <= outstanding - CNT_ONE;
                default: outstanding <= outstanding;
            endcase
            if (push)
                wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)
                rd_ptr <= rd_ptr + PTR_ONE;
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + CNT_ONE;
                2'b01:   fifo_count <= fifo_count - CNT_ONE;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (push)
            fifo_mem[wr_ptr] <= {ch, I_Mem_RData};
    end

    assign O_Done      = done_q;
    assign O_Mem_Req   = mem_req;
    assign O_Mem_We    = (state == STORE);
    assign O_Mem_Addr  = cur_addr;
    assign O_Mem_WData = (state == STORE) ? I_St_Data[int'(ch)*WIDTH_DATA +: WIDTH_DATA] : '0;
    assign O_Ld_Valid  = !fifo_empty;
    assign O_Ld_Data   = fifo_empty ? '0 : rd_word[WIDTH_DATA-1:0];
    assign O_Ld_Ch     = fifo_empty ? '0 : rd_word[WIDTH_DATA +: CW];

    // a return that finds the FIFO full without a pop means the credit rule was broken
    assert property (@(posedge clock) disable iff (!reset) !(rsp_valid && fifo_full && !pop));

endmodule

// File: tb/tb_emem_if_mc.sv
// tb/tb_emem_if_mc.sv - directed self-checking bench for emem_if_mc
// Memory model acks every request and returns data = address two cycles after the ack.

module tb_emem_if_mc;

    logic         clock;
    logic         reset;
    logic [3:0]   I_Cmd_Valid, I_Cmd_St, O_Cmd_Ready;
    logic [127:0] I_Cmd_Addr, I_Cmd_Stride;
    logic [63:0]  I_Cmd_Len;
    logic [3:0]   I_St_Valid, O_St_Ready, O_Done;
    logic [127:0] I_St_Data;
    logic         O_Ld_Valid, I_Ld_Ready;
    logic [31:0]  O_Ld_Data;
    logic [1:0]   O_Ld_Ch;
    logic         O_Mem_Req, O_Mem_We, I_Mem_Ack, I_Mem_RValid;
    logic [31:0]  O_Mem_Addr, O_Mem_WData, I_Mem_RData;

    emem_if_mc dut (
        .clock(clock), .reset(reset),
        .I_Cmd_Valid(I_Cmd_Valid), .I_Cmd_St(I_Cmd_St), .I_Cmd_Addr(I_Cmd_Addr),
        .I_Cmd_Stride(I_Cmd_Stride), .I_Cmd_Len(I_Cmd_Len), .O_Cmd_Ready(O_Cmd_Ready),
        .I_St_Valid(I_St_Valid), .I_St_Data(I_St_Data), .O_St_Ready(O_St_Ready),
        .O_Ld_Valid(O_Ld_Valid), .O_Ld_Data(O_Ld_Data), .O_Ld_Ch(O_Ld_Ch),
        .I_Ld_Ready(I_Ld_Ready), .O_Done(O_Done),
        .O_Mem_Req(O_Mem_Req), .O_Mem_We(O_Mem_We), .O_Mem_Addr(O_Mem_Addr),
        .O_Mem_WData(O_Mem_WData), .I_Mem_Ack(I_Mem_Ack), .I_Mem_RValid(I_Mem_RValid),
        .I_Mem_RData(I_Mem_RData)
    );

    int n_total = 0;
    int n_pass  = 0;
    int cyc     = 0;

    logic [31:0] iss_addr[$], wr_addr[$], wr_data[$], pop_data[$], rq_addr[$];
    logic [1:0]  pop_ch[$];
    int          rq_due[$], grant_q[$];
    int          done_cnt[4], done_cyc[4], st_cnt[4];
    int          req_cnt, acks_pre_pop, ld_valid_cnt, overlap;
    int          grant_cyc, first_req_cyc, first_ack_cyc, last_ack_cyc;
    int          first_pop_cyc, last_pop_cyc, err_a, err_b;
    logic        active;
    logic [3:0]  r;
    logic [31:0] st_words [3];
    logic [31:0] wrap_exp [4];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got 0x%0h, required 0x%0h", tag, got, exp);
    endtask

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial forever begin
        @(posedge clock);
        cyc++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1);
    end

    // external memory read-return model
    initial forever begin
        @(posedge clock);
        #1;
        if (rq_due.size() > 0 && rq_due[0] <= cyc) begin
            I_Mem_RValid = 1'b1;
            I_Mem_RData  = rq_addr.pop_front();
            void'(rq_due.pop_front());
        end else begin
            I_Mem_RValid = 1'b0;
            I_Mem_RData  = '0;
        end
    end

    initial forever begin
        @(negedge clock);
        if (O_Mem_Req) begin
            req_cnt++;
            if (first_req_cyc < 0) first_req_cyc = cyc;
        end
        if (O_Mem_Req && I_Mem_Ack) begin
            last_ack_cyc = cyc;
            if (O_Mem_We) begin
                wr_addr.push_back(O_Mem_Addr);
                wr_data.push_back(O_Mem_WData);
            end else begin
                if (first_ack_cyc < 0) first_ack_cyc = cyc;
                if (pop_data.size() == 0) acks_pre_pop++;
                iss_addr.push_back(O_Mem_Addr);
                rq_addr.push_back(O_Mem_Addr);
                rq_due.push_back(cyc + 2);
            end
        end
        if (O_Ld_Valid) ld_valid_cnt++;
        if (O_Ld_Valid && I_Ld_Ready) begin
            if (first_pop_cyc < 0) first_pop_cyc = cyc;
            last_pop_cyc = cyc;
            pop_data.push_back(O_Ld_Data);
            pop_ch.push_back(O_Ld_Ch);
        end
        for (int i = 0; i < 4; i++) begin
            if (O_Done[i]) begin
                done_cnt[i]++;
                done_cyc[i] = cyc;
                active = 1'b0;
            end
            if (O_St_Ready[i]) st_cnt[i]++;
        end
        if (O_Cmd_Ready != 4'b0) begin
            if (active || $countones(O_Cmd_Ready) != 1) overlap++;
            active    = 1'b1;
            grant_cyc = cyc;
            for (int i = 0; i < 4; i++)
                if (O_Cmd_Ready[i]) grant_q.push_back(i);
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_logs();
        iss_addr.delete(); wr_addr.delete(); wr_data.delete();
        pop_data.delete(); pop_ch.delete(); grant_q.delete();
        for (int i = 0; i < 4; i++) begin
            done_cnt[i] = 0; done_cyc[i] = -1; st_cnt[i] = 0;
        end
        req_cnt = 0; acks_pre_pop = 0; ld_valid_cnt = 0; overlap = 0; active = 1'b0;
        grant_cyc = -1; first_req_cyc = -1; first_ack_cyc = -1; last_ack_cyc = -1;
        first_pop_cyc = -1; last_pop_cyc = -1;
    endtask

    task automatic set_cmd(input int c, input logic st, input logic [31:0] addr,
                           input logic [31:0] stride, input logic [15:0] len);
        I_Cmd_St[c]              = st;
        I_Cmd_Addr[c*32 +: 32]   = addr;
        I_Cmd_Stride[c*32 +: 32] = stride;
        I_Cmd_Len[c*16 +: 16]    = len;
    endtask

    task automatic run_cmd(input int c, input logic st, input logic [31:0] addr,
                           input logic [31:0] stride, input logic [15:0] len);
        bit seen;
        seen = 1'b0;
        set_cmd(c, st, addr, stride, len);
        I_Cmd_Valid[c] = 1'b1;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge clock);
            if (O_Cmd_Ready[c]) seen = 1'b1;
        end
        if (!seen) check($sformatf("cmd_accept_timeout_ch%0d", c), 0, 1);
        tick();
        I_Cmd_Valid[c] = 1'b0;
    endtask

    task automatic wait_done(input int c, input int n);
        for (int i = 0; i < 400 && done_cnt[c] < n; i++) begin
            @(negedge clock);
            #1;
        end
        if (done_cnt[c] < n) check($sformatf("done_timeout_ch%0d", c), done_cnt[c], n);
    endtask

    initial begin
        st_words[0] = 32'hAAAA_0001;
        st_words[1] = 32'hBBBB_0002;
        st_words[2] = 32'hCCCC_0003;
        wrap_exp[0] = 32'hFFFF_FFFE;
        wrap_exp[1] = 32'hFFFF_FFFF;
        wrap_exp[2] = 32'h0000_0000;
        wrap_exp[3] = 32'h0000_0001;
        reset = 1'b0;
        I_Cmd_Valid = '0; I_Cmd_St = '0; I_Cmd_Addr = '0; I_Cmd_Stride = '0; I_Cmd_Len = '0;
        I_St_Valid = '0; I_St_Data = '0; I_Ld_Ready = 1'b1; I_Mem_Ack = 1'b1;
        I_Mem_RValid = 1'b0; I_Mem_RData = '0;
        clear_logs();

        // all four channels request Len=1 loads, held through reset
        for (int c = 0; c < 4; c++) set_cmd(c, 1'b0, 32'h1000 + c*16, 32'd1, 16'd1);
        I_Cmd_Valid = 4'hF;
        repeat (3) @(posedge clock);
        #1;
        check("rst_outputs", 32'({O_Mem_Req, O_Mem_We, O_St_Ready, O_Done, O_Cmd_Ready, O_Ld_Valid}), 0);
        check("rst_mem_addr", O_Mem_Addr, 0);
        check("rst_ld_data", O_Ld_Data, 0);
        tick();
        reset = 1'b1;

        for (int i = 0; i < 100 && I_Cmd_Valid != 4'b0; i++) begin
            @(negedge clock);
            r = O_Cmd_Ready;
            tick();
            I_Cmd_Valid = I_Cmd_Valid & ~r;
        end
        check("t3_all_granted", 32'(I_Cmd_Valid), 0);
        wait_done(0, 1);
        repeat (4) tick();
        check("t3_grant_cnt", grant_q.size(), 4);
        if (grant_q.size() == 4) begin
            check("t3_grant0", grant_q[0], 1);
            check("t3_grant1", grant_q[1], 2);
            check("t3_grant2", grant_q[2], 3);
            check("t3_grant3", grant_q[3], 0);
        end
        for (int c = 0; c < 4; c++) check($sformatf("t3_done_ch%0d", c), done_cnt[c], 1);
        check("t3_overlap", overlap, 0);

        // single-channel load with data = address
        clear_logs();
        run_cmd(0, 1'b0, 32'h100, 32'd1, 16'd4);
        wait_done(0, 1);
        repeat (4) tick();
        check("t1_issue_cnt", iss_addr.size(), 4);
        for (int i = 0; i < iss_addr.size() && i < 4; i++)
            check($sformatf("t1_addr%0d", i), iss_addr[i], 32'h100 + i);
        check("t1_pop_cnt", pop_data.size(), 4);
        for (int i = 0; i < pop_data.size() && i < 4; i++) begin
            check($sformatf("t1_data%0d", i), pop_data[i], 32'h100 + i);
            check($sformatf("t1_ch%0d", i), 32'(pop_ch[i]), 0);
        end
        check("t1_done_cnt", done_cnt[0], 1);
        check("t1_done_after_pop", 32'(done_cyc[0] > last_pop_cyc), 1);
        check("t1_req_latency", first_req_cyc - grant_cyc, 1);
        check("t1_ld_latency", first_pop_cyc - first_ack_cyc, 3);

        // strided store with gapped store data
        clear_logs();
        run_cmd(2, 1'b1, 32'h10, 32'd4, 16'd3);
        for (int k = 0; k < 3; k++) begin
            bit got_rdy;
            got_rdy = 1'b0;
            I_St_Data[64 +: 32] = st_words[k];
            I_St_Valid[2] = 1'b1;
            for (int i = 0; i < 20 && !got_rdy; i++) begin
                @(negedge clock);
                if (O_St_Ready[2]) got_rdy = 1'b1;
            end
            if (!got_rdy) check("t2_st_ready_timeout", 0, 1);
            tick();
            I_St_Valid[2] = 1'b0;
            tick();
        end
        wait_done(2, 1);
        repeat (3) tick();
        check("t2_write_cnt", wr_addr.size(), 3);
        for (int i = 0; i < wr_addr.size() && i < 3; i++) begin
            check($sformatf("t2_waddr%0d", i), wr_addr[i], 32'h10 + 4*i);
            check($sformatf("t2_wdata%0d", i), wr_data[i], st_words[i]);
        end
        check("t2_st_ready_cnt", st_cnt[2], 3);
        check("t2_st_ready_others", st_cnt[0] + st_cnt[1] + st_cnt[3], 0);
        check("t2_done_cnt", done_cnt[2], 1);
        check("t2_done_timing", done_cyc[2] - last_ack_cyc, 1);

        // credit bound with a stalled load sink
        clear_logs();
        I_Ld_Ready = 1'b0;
        run_cmd(3, 1'b0, 32'h300, 32'd1, 16'd20);
        repeat (40) tick();
        check("t4_acks_before_pop", acks_pre_pop, 8);
        I_Ld_Ready = 1'b1;
        wait_done(3, 1);
        repeat (3) tick();
        check("t4_issue_cnt", iss_addr.size(), 20);
        check("t4_pop_cnt", pop_data.size(), 20);
        err_a = 0;
        err_b = 0;
        for (int i = 0; i < pop_data.size() && i < 20; i++) begin
            if (pop_data[i] !== 32'h300 + i) err_a++;
            if (pop_ch[i] !== 2'd3) err_b++;
        end
        check("t4_order_errors", err_a, 0);
        check("t4_ch_errors", err_b, 0);
        check("t4_done_cnt", done_cnt[3], 1);

        // address wrap
        clear_logs();
        run_cmd(1, 1'b0, 32'hFFFF_FFFE, 32'd1, 16'd4);
        wait_done(1, 1);
        repeat (3) tick();
        check("t5_issue_cnt", iss_addr.size(), 4);
        for (int i = 0; i < iss_addr.size() && i < 4; i++)
            check($sformatf("t5_addr%0d", i), iss_addr[i], wrap_exp[i]);

        // zero-length command
        clear_logs();
        run_cmd(1, 1'b0, 32'h500, 32'd1, 16'd0);
        repeat (4) tick();
        check("t6_len0_done_cnt", done_cnt[1], 1);
        check("t6_len0_done_timing", done_cyc[1] - grant_cyc, 1);
        check("t6_len0_no_req", req_cnt, 0);

        // reset mid-load: late read returns must be dropped
        clear_logs();
        run_cmd(1, 1'b0, 32'h200, 32'd1, 16'd4);
        tick();
        tick();
        #2;
        reset = 1'b0;
        #1;
        check("t6_ldrst_outputs", 32'({O_Mem_Req, O_Mem_We, O_St_Ready, O_Done, O_Cmd_Ready, O_Ld_Valid}), 0);
        @(posedge clock);
        #3;
        reset = 1'b1;
        repeat (6) tick();
        check("t6_ldrst_no_ld_valid", ld_valid_cnt, 0);
        check("t6_ldrst_no_done", done_cnt[1], 0);

        // reset mid-store
        clear_logs();
        run_cmd(0, 1'b1, 32'h40, 32'd1, 16'd4);
        I_St_Data[0 +: 32] = 32'h5555_AAAA;
        I_St_Valid[0] = 1'b1;
        tick();
        #2;
        check("t6_strst_req_before", 32'(O_Mem_Req), 1);
        reset = 1'b0;
        #1;
        check("t6_strst_outputs", 32'({O_Mem_Req, O_Mem_We, O_St_Ready, O_Done, O_Cmd_Ready, O_Ld_Valid}), 0);
        check("t6_strst_wdata", O_Mem_WData, 0);
        check("t6_strst_addr", O_Mem_Addr, 0);
        I_St_Valid[0] = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        repeat (8) tick();
        check("t6_strst_no_done", done_cnt[0], 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
